// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Takes the synchronized reset and a PLL lock indication and releases
//   N_STAGES downstream reset domains one at a time, lowest index first,
//   STAGE_DELAY cycles apart. The release starts only after lock has been
//   seen high for LOCK_CYCLES consecutive edges. Lock loss or a software
//   request re-asserts every output and restarts the sequence.
//
// Ports
//   clk           clock
//   reset_sync_n  async active-low reset from the reset synchronizer
//   lock_i        PLL lock, asynchronous to clk (synchronized internally)
//   sw_reset_req  single-cycle request to re-run the sequence
//   rst_out_n     active-low resets, bit k released k-th
//   seq_done      high while every stage is released
//   seq_state     0 WAIT_LOCK, 1 FILTER, 2 RELEASE, 3 DONE, 4 HOLD
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int N_STAGES    = 4,
  parameter int STAGE_DELAY = 16,
  parameter int LOCK_CYCLES = 8,
  parameter int HOLD_CYCLES = 32,
  parameter int SYNC_STAGE  = 2
) (
  input  logic                clk,
  input  logic                reset_sync_n,
  input  logic                lock_i,
  input  logic                sw_reset_req,
  output logic [N_STAGES-1:0] rst_out_n,
  output logic                seq_done,
  output logic [2:0]          seq_state
);

  localparam int LCW  = $clog2(LOCK_CYCLES + 1);
  localparam int DMAX = (STAGE_DELAY > HOLD_CYCLES) ? STAGE_DELAY : HOLD_CYCLES;
  localparam int DCW  = $clog2(DMAX + 1);

  localparam logic [LCW-1:0]      LOCK_LAST  = LCW'(LOCK_CYCLES - 1);
  localparam logic [LCW-1:0]      LOCK_SAT   = LCW'(LOCK_CYCLES);
  localparam logic [DCW-1:0]      STAGE_LAST = DCW'(STAGE_DELAY - 1);
  localparam logic [DCW-1:0]      HOLD_LAST  = DCW'(HOLD_CYCLES - 1);
  localparam logic [DCW-1:0]      DLY_SAT    = DCW'(DMAX);
  localparam logic [N_STAGES-1:0] ALL_REL    = {N_STAGES{1'b1}};
  localparam logic [N_STAGES-1:0] FIRST_REL  = N_STAGES'(1'b1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    FILTER    = 3'd1,
    RELEASE   = 3'd2,
    DONE      = 3'd3,
    HOLD      = 3'd4
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [SYNC_STAGE-1:0] sync_r;
  logic                lock_s;
  logic [LCW-1:0]      lock_cnt_r, lock_cnt_nxt_s;
  logic [DCW-1:0]      dly_cnt_r, dly_cnt_nxt_s;
  logic [N_STAGES-1:0] rst_r, rst_nxt_s;
  logic                done_r, done_nxt_s;

  function automatic logic [LCW-1:0] lock_inc(input logic [LCW-1:0] v);
    if (v >= LOCK_SAT) begin
      return LOCK_SAT;
    end else begin
      return v + LCW'(1);
    end
  endfunction

  function automatic logic [DCW-1:0] dly_inc(input logic [DCW-1:0] v);
    if (v >= DLY_SAT) begin
      return DLY_SAT;
    end else begin
      return v + DCW'(1);
    end
  endfunction

  assign lock_s    = sync_r[SYNC_STAGE-1];
  assign rst_out_n = rst_r;
  assign seq_done  = done_r;
  assign seq_state = state_r;

  // Lock synchronizer: shift lock_i through SYNC_STAGE flops.
  always_ff @(posedge clk or negedge reset_sync_n) begin
    if (!reset_sync_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGE-2:0], lock_i};
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge reset_sync_n) begin
    if (!reset_sync_n) begin
      state_r    <= WAIT_LOCK;
      lock_cnt_r <= '0;
      dly_cnt_r  <= '0;
      rst_r      <= '0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
      dly_cnt_r  <= dly_cnt_nxt_s;
      rst_r      <= rst_nxt_s;
      done_r     <= done_nxt_s;
    end
  end

  // Next-state and next-output logic. Released stages form a thermometer
  // from bit 0, so releasing the next stage is a shift-in of a one; this
  // makes out-of-order release impossible by construction. Lock loss is
  // tested before sw_reset_req so it wins when both are present.
  always_comb begin
    state_nxt_s    = state_r;
    lock_cnt_nxt_s = lock_cnt_r;
    dly_cnt_nxt_s  = dly_cnt_r;
    rst_nxt_s      = rst_r;
    done_nxt_s     = done_r;
    case (state_r)
      WAIT_LOCK: begin
        rst_nxt_s     = '0;
        done_nxt_s    = 1'b0;
        dly_cnt_nxt_s = '0;
        if (lock_s) begin
          state_nxt_s    = FILTER;
          lock_cnt_nxt_s = LCW'(1);
        end else begin
          lock_cnt_nxt_s = '0;
        end
      end
      FILTER: begin
        if (!lock_s) begin
          state_nxt_s    = WAIT_LOCK;
          lock_cnt_nxt_s = '0;
          rst_nxt_s      = '0;
          done_nxt_s     = 1'b0;
        end else if (lock_cnt_r >= LOCK_LAST) begin
          lock_cnt_nxt_s = '0;
          dly_cnt_nxt_s  = '0;
          rst_nxt_s      = FIRST_REL;
          if (FIRST_REL == ALL_REL) begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = RELEASE;
          end
        end else begin
          lock_cnt_nxt_s = lock_inc(lock_cnt_r);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_nxt_s   = WAIT_LOCK;
          dly_cnt_nxt_s = '0;
          rst_nxt_s     = '0;
          done_nxt_s    = 1'b0;
        end else if (sw_reset_req) begin
          state_nxt_s   = HOLD;
          dly_cnt_nxt_s = '0;
          rst_nxt_s     = '0;
          done_nxt_s    = 1'b0;
        end else if (dly_cnt_r >= STAGE_LAST) begin
          dly_cnt_nxt_s = '0;
          rst_nxt_s     = (rst_r << 1) | FIRST_REL;
          if (((rst_r << 1) | FIRST_REL) == ALL_REL) begin
            state_nxt_s = DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = RELEASE;
          end
        end else begin
          dly_cnt_nxt_s = dly_inc(dly_cnt_r);
        end
      end
      DONE: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
          rst_nxt_s   = '0;
          done_nxt_s  = 1'b0;
        end else if (sw_reset_req) begin
          state_nxt_s   = HOLD;
          dly_cnt_nxt_s = '0;
          rst_nxt_s     = '0;
          done_nxt_s    = 1'b0;
        end else begin
          rst_nxt_s  = ALL_REL;
          done_nxt_s = 1'b1;
        end
      end
      HOLD: begin
        rst_nxt_s  = '0;
        done_nxt_s = 1'b0;
        if (!lock_s) begin
          state_nxt_s   = WAIT_LOCK;
          dly_cnt_nxt_s = '0;
        end else if (dly_cnt_r >= HOLD_LAST) begin
          // Full filter is re-applied after a software restart.
          state_nxt_s    = FILTER;
          lock_cnt_nxt_s = '0;
          dly_cnt_nxt_s  = '0;
        end else begin
          dly_cnt_nxt_s = dly_inc(dly_cnt_r);
        end
      end
      default: begin
        state_nxt_s    = WAIT_LOCK;
        lock_cnt_nxt_s = '0;
        dly_cnt_nxt_s  = '0;
        rst_nxt_s      = '0;
        done_nxt_s     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Self-checking bench for reset_sequencer with default parameters.
//   A behavioural model tracks the sequencer phase and the time since the
//   first stage release; expected outputs are derived arithmetically from
//   those and compared on every falling clock edge. Directed scenarios add
//   hand-computed expectations at specific edges; a randomized phase then
//   exercises lock drops, software requests and async resets.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int N  = 4;
  localparam int SD = 16;
  localparam int LC = 8;
  localparam int HC = 32;

  logic       clk = 1'b0;
  logic       reset_sync_n = 1'b0;
  logic       lock_i = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic [3:0] rst_out_n;
  logic       seq_done;
  logic [2:0] seq_state;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .N_STAGES(N), .STAGE_DELAY(SD), .LOCK_CYCLES(LC), .HOLD_CYCLES(HC), .SYNC_STAGE(2)
  ) dut (
    .clk(clk),
    .reset_sync_n(reset_sync_n),
    .lock_i(lock_i),
    .sw_reset_req(sw_reset_req),
    .rst_out_n(rst_out_n),
    .seq_done(seq_done),
    .seq_state(seq_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_WAIT, M_FILT, M_RUN, M_HOLD} mphase_t;
  mphase_t m_ph   = M_WAIT;
  int      m_filt = 0;   // consecutive lock-high edges seen while filtering
  int      m_t    = 0;   // edges since stage 0 was released
  int      m_hold = 0;   // edges spent in hold
  bit      m_h1   = 1'b0;
  bit      m_h2   = 1'b0;

  always @(posedge clk or negedge reset_sync_n) begin
    bit ls;
    if (!reset_sync_n) begin
      m_ph = M_WAIT; m_filt = 0; m_t = 0; m_hold = 0; m_h1 = 1'b0; m_h2 = 1'b0;
    end else begin
      // lock as seen by the sequencer is lock_i from two edges earlier
      ls = m_h2; m_h2 = m_h1; m_h1 = lock_i;
      case (m_ph)
        M_WAIT: if (ls) begin m_ph = M_FILT; m_filt = 1; end
        M_FILT: begin
          if (!ls) m_ph = M_WAIT;
          else begin
            m_filt++;
            if (m_filt == LC) begin m_ph = M_RUN; m_t = 0; end
          end
        end
        M_RUN: begin
          if (!ls) m_ph = M_WAIT;
          else if (sw_reset_req) begin m_ph = M_HOLD; m_hold = 0; end
          else if (m_t < 1000000) m_t++;
        end
        M_HOLD: begin
          if (!ls) m_ph = M_WAIT;
          else begin
            m_hold++;
            if (m_hold == HC) begin m_ph = M_FILT; m_filt = 0; end
          end
        end
        default: m_ph = M_WAIT;
      endcase
    end
  end

  // Compare DUT outputs with the model away from the active edge.
  always @(negedge clk) begin
    int         rel;
    logic [3:0] e_rst;
    logic       e_done;
    logic [2:0] e_st;
    if (chk_en) begin
      rel = 0; e_rst = 4'd0; e_done = 1'b0; e_st = 3'd0;
      case (m_ph)
        M_WAIT: e_st = 3'd0;
        M_FILT: e_st = 3'd1;
        M_HOLD: e_st = 3'd4;
        M_RUN: begin
          rel = m_t / SD + 1;
          if (rel > N) rel = N;
          e_rst  = 4'((1 << rel) - 1);
          e_done = (rel == N);
          e_st   = e_done ? 3'd3 : 3'd2;
        end
        default: e_st = 3'd0;
      endcase
      check("model_rst_out_n", 32'(rst_out_n), 32'(e_rst));
      check("model_seq_done", 32'(seq_done), 32'(e_done));
      check("model_seq_state", 32'(seq_state), 32'(e_st));
    end
  end

  // Full release sequence from a cleared synchronizer; called just after a
  // rising edge so the next rising edge is E0.
  task automatic seq_from_e0(input string tag);
    lock_i = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      @(posedge clk); #1;
      case (k)
        8:  check({tag, "_E8_rst"}, 32'(rst_out_n), 32'h0);
        9:  check({tag, "_E9_rst"}, 32'(rst_out_n), 32'h1);
        24: check({tag, "_E24_rst"}, 32'(rst_out_n), 32'h1);
        25: check({tag, "_E25_rst"}, 32'(rst_out_n), 32'h3);
        40: check({tag, "_E40_rst"}, 32'(rst_out_n), 32'h3);
        41: check({tag, "_E41_rst"}, 32'(rst_out_n), 32'h7);
        56: begin
          check({tag, "_E56_rst"}, 32'(rst_out_n), 32'h7);
          check({tag, "_E56_done"}, 32'(seq_done), 32'h0);
        end
        57: begin
          check({tag, "_E57_rst"}, 32'(rst_out_n), 32'hF);
          check({tag, "_E57_done"}, 32'(seq_done), 32'h1);
        end
        60: check({tag, "_E60_state"}, 32'(seq_state), 32'h3);
        default: ;
      endcase
    end
  endtask

  initial begin
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_sync_n = 1'b1;

    // 1: lock held low
    repeat (100) @(posedge clk);
    #1;
    check("t1_rst", 32'(rst_out_n), 32'h0);
    check("t1_state", 32'(seq_state), 32'h0);
    check("t1_done", 32'(seq_done), 32'h0);

    // 2: clean release
    seq_from_e0("t2");

    // 3: one-cycle lock glitch after 5 filter edges
    lock_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    lock_i = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 4) lock_i = 1'b0;
      if (k == 5) lock_i = 1'b1;
      case (k)
        6:  check("t3_E6_state", 32'(seq_state), 32'h1);
        7:  check("t3_E7_state", 32'(seq_state), 32'h0);
        8:  check("t3_E8_state", 32'(seq_state), 32'h1);
        9:  check("t3_E9_rst", 32'(rst_out_n), 32'h0);
        14: check("t3_E14_rst", 32'(rst_out_n), 32'h0);
        15: check("t3_E15_rst", 32'(rst_out_n), 32'h1);
        default: ;
      endcase
    end
    repeat (50) begin @(posedge clk); #1; end

    // 4: software restart from DONE; extra requests in HOLD/FILTER ignored
    check("t4_pre_state", 32'(seq_state), 32'h3);
    sw_reset_req = 1'b1;
    for (int k = 0; k <= 90; k++) begin
      @(posedge clk); #1;
      sw_reset_req = (k == 10 || k == 35) ? 1'b1 : 1'b0;
      case (k)
        0: begin
          check("t4_S_state", 32'(seq_state), 32'h4);
          check("t4_S_rst", 32'(rst_out_n), 32'h0);
          check("t4_S_done", 32'(seq_done), 32'h0);
        end
        31: check("t4_S31_state", 32'(seq_state), 32'h4);
        32: check("t4_S32_state", 32'(seq_state), 32'h1);
        39: check("t4_S39_rst", 32'(rst_out_n), 32'h0);
        40: check("t4_S40_rst", 32'(rst_out_n), 32'h1);
        88: begin
          check("t4_S88_rst", 32'(rst_out_n), 32'hF);
          check("t4_S88_done", 32'(seq_done), 32'h1);
        end
        default: ;
      endcase
    end

    // 5a: lock drop after stage 1 released
    lock_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    lock_i = 1'b1;
    for (int k = 0; k <= 36; k++) begin
      @(posedge clk); #1;
      if (k == 30) lock_i = 1'b0;
      case (k)
        32: check("t5a_E32_rst", 32'(rst_out_n), 32'h3);
        33: begin
          check("t5a_E33_rst", 32'(rst_out_n), 32'h0);
          check("t5a_E33_state", 32'(seq_state), 32'h0);
        end
        default: ;
      endcase
    end

    // 5b: lock loss seen together with sw_reset_req
    lock_i = 1'b1;
    for (int k = 0; k <= 36; k++) begin
      @(posedge clk); #1;
      if (k == 30) lock_i = 1'b0;
      sw_reset_req = (k == 32) ? 1'b1 : 1'b0;
      case (k)
        32: check("t5b_E32_state", 32'(seq_state), 32'h2);
        33: begin
          check("t5b_E33_state", 32'(seq_state), 32'h0);
          check("t5b_E33_rst", 32'(rst_out_n), 32'h0);
        end
        34: check("t5b_E34_state", 32'(seq_state), 32'h0);
        default: ;
      endcase
    end

    // 6: async reset mid-RELEASE, then identical re-sequence
    lock_i = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(posedge clk); #1;
    end
    check("t6_pre_rst", 32'(rst_out_n), 32'h3);
    #2 reset_sync_n = 1'b0;
    #1;
    check("t6_async_rst", 32'(rst_out_n), 32'h0);
    check("t6_async_done", 32'(seq_done), 32'h0);
    check("t6_async_state", 32'(seq_state), 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    reset_sync_n = 1'b1;
    seq_from_e0("t6");

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (lock_i) lock_i = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      else        lock_i = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      sw_reset_req = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 1499) == 0) begin
        reset_sync_n = 1'b0;
        #2 reset_sync_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    sw_reset_req = 1'b0;
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
